// File: rtl/float_types_pkg.sv
// rtl/float_types_pkg.sv - shared FPU widths, stage-1 beat layout and LZ-width helper
package float_types_pkg;

  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 23;
  localparam int FP_RAW_W  = FP_MANT_W + 5;
  localparam int FP_NORM_W = FP_MANT_W + 4;

  function automatic int lz_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int FP_LZ_W = lz_width(FP_NORM_W);

  // Normalised beat for the default widths: {hidden, frac, G, R, S} in mant
  typedef struct packed {
    logic                        sign;
    logic signed [FP_EXP_W+1:0]  exp;
    logic [FP_NORM_W-1:0]        mant;
    logic                        zero;
  } fp_s1_t;

endpackage

// File: rtl/fp_lzc.sv
// rtl/fp_lzc.sv - combinational leading-zero counter with all-zero flag
module fp_lzc
  import float_types_pkg::*;
#(
  parameter  int WIDTH = FP_NORM_W,
  localparam int CNT_W = lz_width(WIDTH)
) (
  input  logic [WIDTH-1:0] data_i,
  output logic [CNT_W-1:0] count_o,
  output logic             all_zero_o
);

  // Scan upward so the highest set bit is the last one to write the count
  always_comb begin
    count_o = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (data_i[i]) begin
        count_o = CNT_W'(WIDTH - 1 - i);
      end
    end
  end

  assign all_zero_o = ~|data_i;

endmodule

// File: rtl/fp_norm_round_stage.sv
// rtl/fp_norm_round_stage.sv - two-stage normalise/round/pack after the FPU mantissa add
// FP_NORM_ROUND_EN selects round-to-nearest-even; otherwise the result is truncated.
module fp_norm_round_stage
  import float_types_pkg::*;
#(
  parameter int EXP_W  = FP_EXP_W,
  parameter int MANT_W = FP_MANT_W,
  parameter int BIAS   = (1 << (EXP_W - 1)) - 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic                    sign_i,
  input  logic [EXP_W-1:0]        exp_i,
  input  logic [MANT_W+4:0]       mant_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [EXP_W+MANT_W:0]   result_o,
  output logic                    zero_o,
  output logic                    overflow_o,
  output logic                    underflow_o
);

  localparam int NORM_W = MANT_W + 4;
  localparam int LZ_W   = lz_width(NORM_W);
  localparam int XW     = EXP_W + 2;
  localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

  typedef struct packed {
    logic                 sign;
    logic signed [XW-1:0] exp;
    logic [NORM_W-1:0]    mant;
    logic                 zero;
  } s1_t;

  logic s1_en, s2_en;
  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  s1_t  s1_q, s1_d;
  logic [EXP_W+MANT_W:0] result_q, result_d;
  logic zero_q, zero_d, ovf_q, ovf_d, unf_q, unf_d;

  logic [LZ_W-1:0]      lz;
  logic                 lz_all_zero;
  logic                 carry_in;
  logic signed [XW-1:0] exp_ext;

  logic [MANT_W-1:0]    frac_r;
  logic signed [XW-1:0] exp_r;

  assign s2_en   = !s2_valid_q || ready_i;
  assign s1_en   = !s1_valid_q || s2_en;
  assign ready_o = s1_en;

  assign carry_in = mant_i[MANT_W+4];
  assign exp_ext  = signed'(XW'(exp_i));

  fp_lzc #(.WIDTH(NORM_W)) u_lzc (
    .data_i     (mant_i[NORM_W-1:0]),
    .count_o    (lz),
    .all_zero_o (lz_all_zero)
  );

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (s1_en) begin
      s1_valid_d = valid_i;
      if (valid_i) begin
        s1_d.sign = sign_i;
        s1_d.zero = !carry_in && lz_all_zero;
        if (carry_in) begin
          s1_d.mant = {mant_i[MANT_W+4:2], mant_i[1] | mant_i[0]};
          s1_d.exp  = exp_ext + XW'(1);
        end else if (lz_all_zero) begin
          s1_d.mant = '0;
          s1_d.exp  = exp_ext;
        end else begin
          s1_d.mant = mant_i[NORM_W-1:0] << lz;
          s1_d.exp  = exp_ext - XW'(lz);
        end
      end
    end
  end

`ifdef FP_NORM_ROUND_EN
  logic round_up, rnd_carry;
  logic unused_hidden;

  // Hidden bit is always set for a nonzero beat, so a fraction carry-out is the hidden-bit carry
  assign unused_hidden = s1_q.mant[NORM_W-1];
  assign round_up = s1_q.mant[2] && (s1_q.mant[1] || s1_q.mant[0] || s1_q.mant[3]);

  always_comb begin
    {rnd_carry, frac_r} = {1'b0, s1_q.mant[NORM_W-2:3]} + (MANT_W + 1)'(round_up);
    exp_r = s1_q.exp + XW'(rnd_carry);
  end
`else
  logic [3:0] unused_low;

  assign unused_low = {s1_q.mant[NORM_W-1], s1_q.mant[2:0]};

  always_comb begin
    frac_r = s1_q.mant[NORM_W-2:3];
    exp_r  = s1_q.exp;
  end
`endif

  always_comb begin
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    zero_d     = zero_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    if (s2_en) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        zero_d = 1'b0;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        if (s1_q.zero) begin
          result_d = '0;
          zero_d   = 1'b1;
        end else if (exp_r >= EXP_MAX) begin
          result_d = {s1_q.sign, {EXP_W{1'b1}}, {MANT_W{1'b0}}};
          ovf_d    = 1'b1;
        end else if (exp_r[XW-1] || exp_r == '0) begin
          result_d = {s1_q.sign, {(EXP_W + MANT_W){1'b0}}};
          unf_d    = 1'b1;
        end else begin
          result_d = {s1_q.sign, exp_r[EXP_W-1:0], frac_r};
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_q       <= s1_d;
      result_q   <= result_d;
      zero_q     <= zero_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
    end
  end

  assign valid_o     = s2_valid_q;
  assign result_o    = result_q;
  assign zero_o      = zero_q;
  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;

  a_flags_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    valid_o |-> $onehot0({zero_o, overflow_o, underflow_o}));

  a_finite_range: assert property (@(posedge clk_i) disable iff (rst_i)
    (valid_o && !zero_o && !overflow_o && !underflow_o)
      |-> (int'(result_o[EXP_W+MANT_W-1:MANT_W]) - BIAS <= BIAS));

endmodule

// File: tb/tb_fp_norm_round_stage.sv
// tb/tb_fp_norm_round_stage.sv - directed self-checking bench for fp_norm_round_stage
module tb_fp_norm_round_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic        sign_i;
  logic [7:0]  exp_i;
  logic [27:0] mant_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] result_o;
  logic        zero_o, overflow_o, underflow_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  fp_norm_round_stage #(.EXP_W(8), .MANT_W(23)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .sign_i      (sign_i),
    .exp_i       (exp_i),
    .mant_i      (mant_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .result_o    (result_o),
    .zero_o      (zero_o),
    .overflow_o  (overflow_o),
    .underflow_o (underflow_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // flags are {zero, overflow, underflow}
  task automatic run_vec(input string tag, input logic s, input logic [7:0] e,
                         input logic [27:0] m, input logic [31:0] r, input logic [2:0] f);
    int lat;
    @(negedge clk_i);
    sign_i  = s;
    exp_i   = e;
    mant_i  = m;
    valid_i = 1'b1;
    @(posedge clk_i);
    #1 valid_i = 1'b0;
    lat = 0;
    while (lat < 8) begin
      @(negedge clk_i);
      lat++;
      if (valid_o) break;
    end
    chk({tag, "_lat"}, 32'(lat), 32'd2);
    chk({tag, "_res"}, result_o, r);
    chk({tag, "_flg"}, {29'd0, zero_o, overflow_o, underflow_o}, {29'd0, f});
  endtask

  logic [31:0] bp_exp [4];
  int sent, recv;

  initial begin
    rst_i   = 1'b1;
    valid_i = 1'b0;
    ready_i = 1'b1;
    sign_i  = 1'b0;
    exp_i   = '0;
    mant_i  = '0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    #1;
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    chk("rst_result", result_o, 32'd0);
    chk("rst_flags", {29'd0, zero_o, overflow_o, underflow_o}, 32'd0);

    run_vec("carry",    1'b0, 8'd127, 28'hC000000, 32'h40400000, 3'b000);
    run_vec("cancel",   1'b0, 8'd127, 28'h0000008, 32'h34000000, 3'b000);
    run_vec("zero",     1'b1, 8'd127, 28'h0000000, 32'h00000000, 3'b100);
    run_vec("ovf",      1'b0, 8'd254, 28'hC000000, 32'h7F800000, 3'b010);
    run_vec("unf",      1'b1, 8'd10,  28'h0000008, 32'h80000000, 3'b001);
    run_vec("ovf_edge", 1'b0, 8'd255, 28'h4000000, 32'h7F800000, 3'b010);
    run_vec("max_fin",  1'b0, 8'd254, 28'h4000000, 32'h7F000000, 3'b000);
    run_vec("unf_edge", 1'b0, 8'd1,   28'h2000000, 32'h00000000, 3'b001);
    run_vec("min_norm", 1'b0, 8'd2,   28'h2000000, 32'h00800000, 3'b000);
    run_vec("neg_stky", 1'b1, 8'd127, 28'h8000001, 32'hC0000000, 3'b000);
    run_vec("tie_even", 1'b0, 8'd127, 28'h4000004, 32'h3F800000, 3'b000);
`ifdef FP_NORM_ROUND_EN
    run_vec("round",    1'b0, 8'd127, 28'h7FFFFFC, 32'h40000000, 3'b000);
    run_vec("tie_odd",  1'b0, 8'd127, 28'h400000C, 32'h3F800002, 3'b000);
`else
    run_vec("round",    1'b0, 8'd127, 28'h7FFFFFC, 32'h3FFFFFFF, 3'b000);
    run_vec("tie_odd",  1'b0, 8'd127, 28'h400000C, 32'h3F800001, 3'b000);
`endif

    // Backpressure: four carry beats, exp 100..103, downstream stalled for four cycles
    bp_exp[0] = 32'h32C00000;
    bp_exp[1] = 32'h33400000;
    bp_exp[2] = 32'h33C00000;
    bp_exp[3] = 32'h34400000;
    sent = 0;
    recv = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk_i);
      ready_i = (cyc >= 4);
      if (sent < 4) begin
        valid_i = 1'b1;
        sign_i  = 1'b0;
        exp_i   = 8'(100 + sent);
        mant_i  = 28'hC000000;
      end else begin
        valid_i = 1'b0;
      end
      #1;
      if (cyc == 3) begin
        chk("bp_accepted", 32'(sent), 32'd2);
        chk("bp_ready_low", {31'd0, ready_o}, 32'd0);
      end
      if (cyc == 2 || cyc == 3) begin
        chk("bp_hold_valid", {31'd0, valid_o}, 32'd1);
        chk("bp_hold_res", result_o, bp_exp[0]);
      end
      if (cyc >= 4 && cyc <= 7) chk("bp_nobubble", {31'd0, valid_o}, 32'd1);
      if (valid_o && ready_i) begin
        if (recv < 4) chk("bp_order", result_o, bp_exp[recv]);
        recv++;
      end
      if (valid_i && ready_o) sent++;
      if (sent == 4 && recv >= 4) break;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    chk("bp_recv", 32'(recv), 32'd4);

    // Reset while a beat is in flight must drop it
    @(negedge clk_i);
    exp_i   = 8'd127;
    mant_i  = 28'hC000000;
    valid_i = 1'b1;
    @(posedge clk_i);
    #1 valid_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("rst_drop", {31'd0, valid_o}, 32'd0);
      @(negedge clk_i);
    end
    run_vec("post_rst", 1'b0, 8'd127, 28'hC000000, 32'h40400000, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
